// File: rtl/hit_resolver.sv
// Frame-tick driven hit resolution between two fighters: collision, per-attack reach,
// one hit per attack window, hit/block stun timers, health and a sticky game-over flag.
module hit_resolver #(
  parameter int CHAR_WIDTH       = 128,
  parameter int REACH_BASIC      = 64,
  parameter int REACH_DIR        = 96,
  parameter int HITSTUN_FRAMES   = 15,
  parameter int BLOCKSTUN_FRAMES = 8,
  parameter int CNT_W            = 5,
  parameter int HEALTH_MAX       = 3,
  parameter int HEALTH_W         = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic [9:0]          char1_pos_x,
  input  logic [3:0]          char1_state,
  input  logic                char1_block_flag,
  input  logic [9:0]          char2_pos_x,
  input  logic [3:0]          char2_state,
  input  logic                char2_block_flag,
  output logic                collision_flag,
  output logic [1:0]          char1_frame_state,
  output logic [1:0]          char2_frame_state,
  output logic [CNT_W-1:0]    char1_stun_left,
  output logic [CNT_W-1:0]    char2_stun_left,
  output logic [HEALTH_W-1:0] char1_health,
  output logic [HEALTH_W-1:0] char2_health,
  output logic                char1_hit_pulse,
  output logic                char2_hit_pulse,
  output logic                game_over
);

  localparam logic [3:0] S_ATTACK_ACTIVE     = 4'b0100;
  localparam logic [3:0] S_ATTACK_DIR_ACTIVE = 4'b0111;
  localparam logic [3:0] S_STUN              = 4'b1001;

  localparam logic [10:0]         CW11       = 11'(CHAR_WIDTH);
  localparam logic [10:0]         RB11       = 11'(REACH_BASIC);
  localparam logic [10:0]         RD11       = 11'(REACH_DIR);
  localparam logic [CNT_W-1:0]    HIT_LOAD   = CNT_W'(HITSTUN_FRAMES);
  localparam logic [CNT_W-1:0]    BLOCK_LOAD = CNT_W'(BLOCKSTUN_FRAMES);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [HEALTH_W-1:0] H_MAX      = HEALTH_W'(HEALTH_MAX);
  localparam logic [HEALTH_W-1:0] H_ONE      = HEALTH_W'(1);

  typedef enum logic [1:0] {
    NOHIT     = 2'b00,
    HITSTUN   = 2'b01,
    BLOCKSTUN = 2'b10
  } frame_state_t;

  frame_state_t        fs1_q, fs1_d, fs2_q, fs2_d;
  logic [CNT_W-1:0]    stun1_q, stun1_d, stun2_q, stun2_d;
  logic [HEALTH_W-1:0] health1_q, health1_d, health2_q, health2_d;
  logic                consumed1_q, consumed1_d, consumed2_q, consumed2_d;
  logic                game_over_d;

  logic [10:0] c1_front, c2_left;
  logic [10:0] reach1, reach2;
  logic        att1, att2;
  logic        raw1, raw2;
  logic        hit_on2, hit_on1, trade;

  // Everything is compared as (left side + extension) >= right side, so 11 bits never wrap.
  assign c1_front = {1'b0, char1_pos_x} + CW11;
  assign c2_left  = {1'b0, char2_pos_x};

  always_comb begin
    att1   = 1'b0;
    reach1 = 11'd0;
    case (char1_state)
      S_ATTACK_ACTIVE:     begin att1 = 1'b1; reach1 = RB11; end
      S_ATTACK_DIR_ACTIVE: begin att1 = 1'b1; reach1 = RD11; end
      default: ;
    endcase
  end

  always_comb begin
    att2   = 1'b0;
    reach2 = 11'd0;
    case (char2_state)
      S_ATTACK_ACTIVE:     begin att2 = 1'b1; reach2 = RB11; end
      S_ATTACK_DIR_ACTIVE: begin att2 = 1'b1; reach2 = RD11; end
      default: ;
    endcase
  end

  assign raw1 = att1 && !consumed1_q && (c1_front + reach1 >= c2_left);
  assign raw2 = att2 && !consumed2_q && (c2_left <= c1_front + reach2);

  assign hit_on2 = frame_tick && raw1 && (fs2_q == NOHIT) && (char2_state != S_STUN) && !game_over;
  assign hit_on1 = frame_tick && raw2 && (fs1_q == NOHIT) && (char1_state != S_STUN) && !game_over;
  assign trade   = hit_on1 && hit_on2;

  // A trade forces both sides into hitstun regardless of blocking.
  always_comb begin
    fs1_d     = fs1_q;
    stun1_d   = stun1_q;
    health1_d = health1_q;
    if (frame_tick) begin
      if (hit_on1) begin
        if (char1_block_flag && !trade) begin
          fs1_d   = BLOCKSTUN;
          stun1_d = BLOCK_LOAD;
        end else begin
          fs1_d   = HITSTUN;
          stun1_d = HIT_LOAD;
          if (health1_q != '0) health1_d = health1_q - H_ONE;
        end
      end else if (stun1_q > CNT_ONE) begin
        stun1_d = stun1_q - CNT_ONE;
      end else if (stun1_q == CNT_ONE) begin
        stun1_d = '0;
        fs1_d   = NOHIT;
      end
    end
  end

  always_comb begin
    fs2_d     = fs2_q;
    stun2_d   = stun2_q;
    health2_d = health2_q;
    if (frame_tick) begin
      if (hit_on2) begin
        if (char2_block_flag && !trade) begin
          fs2_d   = BLOCKSTUN;
          stun2_d = BLOCK_LOAD;
        end else begin
          fs2_d   = HITSTUN;
          stun2_d = HIT_LOAD;
          if (health2_q != '0) health2_d = health2_q - H_ONE;
        end
      end else if (stun2_q > CNT_ONE) begin
        stun2_d = stun2_q - CNT_ONE;
      end else if (stun2_q == CNT_ONE) begin
        stun2_d = '0;
        fs2_d   = NOHIT;
      end
    end
  end

  // The consumed latch re-arms only once the attacker leaves its active window.
  assign consumed1_d = att1 ? (consumed1_q | hit_on2) : 1'b0;
  assign consumed2_d = att2 ? (consumed2_q | hit_on1) : 1'b0;
  assign game_over_d = game_over | (frame_tick && (health1_d == '0 || health2_d == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collision_flag  <= 1'b0;
      fs1_q           <= NOHIT;
      fs2_q           <= NOHIT;
      stun1_q         <= '0;
      stun2_q         <= '0;
      health1_q       <= H_MAX;
      health2_q       <= H_MAX;
      consumed1_q     <= 1'b0;
      consumed2_q     <= 1'b0;
      char1_hit_pulse <= 1'b0;
      char2_hit_pulse <= 1'b0;
      game_over       <= 1'b0;
    end else begin
      collision_flag  <= (c1_front >= c2_left);
      fs1_q           <= fs1_d;
      fs2_q           <= fs2_d;
      stun1_q         <= stun1_d;
      stun2_q         <= stun2_d;
      health1_q       <= health1_d;
      health2_q       <= health2_d;
      consumed1_q     <= consumed1_d;
      consumed2_q     <= consumed2_d;
      char1_hit_pulse <= hit_on1;
      char2_hit_pulse <= hit_on2;
      game_over       <= game_over_d;
    end
  end

  assign char1_frame_state = fs1_q;
  assign char2_frame_state = fs2_q;
  assign char1_stun_left   = stun1_q;
  assign char2_stun_left   = stun2_q;
  assign char1_health      = health1_q;
  assign char2_health      = health2_q;

endmodule

// File: tb/tb_hit_resolver.sv
// Self-checking bench for hit_resolver: directed scenarios plus randomized ticks,
// with a frame-level reference model feeding an expected-result queue.
module tb_hit_resolver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [9:0] char1_pos_x = '0;
  logic [3:0] char1_state = '0;
  logic       char1_block_flag = 1'b0;
  logic [9:0] char2_pos_x = '0;
  logic [3:0] char2_state = '0;
  logic       char2_block_flag = 1'b0;
  logic       collision_flag;
  logic [1:0] char1_frame_state, char2_frame_state;
  logic [4:0] char1_stun_left, char2_stun_left;
  logic [1:0] char1_health, char2_health;
  logic       char1_hit_pulse, char2_hit_pulse, game_over;

  hit_resolver dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .char1_pos_x(char1_pos_x), .char1_state(char1_state), .char1_block_flag(char1_block_flag),
    .char2_pos_x(char2_pos_x), .char2_state(char2_state), .char2_block_flag(char2_block_flag),
    .collision_flag(collision_flag),
    .char1_frame_state(char1_frame_state), .char2_frame_state(char2_frame_state),
    .char1_stun_left(char1_stun_left), .char2_stun_left(char2_stun_left),
    .char1_health(char1_health), .char2_health(char2_health),
    .char1_hit_pulse(char1_hit_pulse), .char2_hit_pulse(char2_hit_pulse),
    .game_over(game_over)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int p2_count = 0;
  logic [21:0] exp_q[$];

  // reference model state
  int m_fs1, m_fs2, m_st1, m_st2, m_h1, m_h2;
  bit m_go, m_con1, m_con2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int reach_of(input logic [3:0] s);
    if (s == 4'b0100) return 64;
    if (s == 4'b0111) return 96;
    return -1;
  endfunction

  task automatic victim(input bit hit, input bit blk, inout int fs, inout int st, inout int h);
    if (hit) begin
      if (blk) begin fs = 2; st = 8; end
      else begin fs = 1; st = 15; if (h > 0) h--; end
    end else if (st > 0) begin
      st--;
      if (st == 0) fs = 0;
    end
  endtask

  task automatic model_reset();
    m_fs1 = 0; m_fs2 = 0; m_st1 = 0; m_st2 = 0;
    m_h1 = 3; m_h2 = 3; m_go = 0; m_con1 = 0; m_con2 = 0;
  endtask

  task automatic model_step();
    int  r1, r2, x1, x2;
    bit  l1, l2, tr, col;
    r1 = reach_of(char1_state);
    r2 = reach_of(char2_state);
    x1 = int'(char1_pos_x);
    x2 = int'(char2_pos_x);
    l1 = (r1 >= 0) && !m_con1 && (x1 + 128 + r1 >= x2) && (m_fs2 == 0) && (char2_state != 4'd9) && !m_go;
    l2 = (r2 >= 0) && !m_con2 && (x1 + 128 + r2 >= x2) && (m_fs1 == 0) && (char1_state != 4'd9) && !m_go;
    tr = l1 && l2;
    victim(l2, char1_block_flag && !tr, m_fs1, m_st1, m_h1);
    victim(l1, char2_block_flag && !tr, m_fs2, m_st2, m_h2);
    if (r1 < 0) m_con1 = 0; else if (l1) m_con1 = 1;
    if (r2 < 0) m_con2 = 0; else if (l2) m_con2 = 1;
    if (m_h1 == 0 || m_h2 == 0) m_go = 1;
    col = (x1 + 128 >= x2);
    exp_q.push_back({col, 2'(m_fs1), 2'(m_fs2), 5'(m_st1), 5'(m_st2), 2'(m_h1), 2'(m_h2), l2, l1, m_go});
  endtask

  // driver: one frame tick with the currently applied inputs, then score the result
  task automatic tick();
    logic [21:0] e, o;
    @(negedge clk);
    model_step();
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    o = {collision_flag, char1_frame_state, char2_frame_state, char1_stun_left, char2_stun_left,
         char1_health, char2_health, char1_hit_pulse, char2_hit_pulse, game_over};
    if (char2_hit_pulse) p2_count++;
    e = exp_q.pop_front();
    check("collision", 32'(o[21]), 32'(e[21]));
    check("c1_frame_state", 32'(o[20:19]), 32'(e[20:19]));
    check("c2_frame_state", 32'(o[18:17]), 32'(e[18:17]));
    check("c1_stun_left", 32'(o[16:12]), 32'(e[16:12]));
    check("c2_stun_left", 32'(o[11:7]), 32'(e[11:7]));
    check("c1_health", 32'(o[6:5]), 32'(e[6:5]));
    check("c2_health", 32'(o[4:3]), 32'(e[4:3]));
    check("c1_hit_pulse", 32'(o[2]), 32'(e[2]));
    check("c2_hit_pulse", 32'(o[1]), 32'(e[1]));
    check("game_over", 32'(o[0]), 32'(e[0]));
  endtask

  // asynchronous reset applied between clock edges, outputs checked before any edge
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_collision", 32'(collision_flag), 0);
    check("rst_c1_fs", 32'(char1_frame_state), 0);
    check("rst_c2_fs", 32'(char2_frame_state), 0);
    check("rst_c1_stun", 32'(char1_stun_left), 0);
    check("rst_c2_stun", 32'(char2_stun_left), 0);
    check("rst_c1_health", 32'(char1_health), 3);
    check("rst_c2_health", 32'(char2_health), 3);
    check("rst_pulses", 32'({char1_hit_pulse, char2_hit_pulse}), 0);
    check("rst_game_over", 32'(game_over), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_inputs(input int x1, input int s1, input bit b1, input int x2, input int s2, input bit b2);
    char1_pos_x = 10'(x1); char1_state = 4'(s1); char1_block_flag = b1;
    char2_pos_x = 10'(x2); char2_state = 4'(s2); char2_block_flag = b2;
  endtask

  logic [3:0] state_tbl [7] = '{4'd0, 4'd4, 4'd4, 4'd7, 4'd7, 4'd9, 4'd2};

  initial begin
    model_reset();
    do_reset();

    // out of reach, then exactly at reach
    set_inputs(100, 4, 0, 300, 0, 0);
    tick();
    check("plan_far_pulse", 32'(char2_hit_pulse), 0);
    set_inputs(100, 4, 0, 292, 0, 0);
    tick();
    check("plan_hit_fs", 32'(char2_frame_state), 1);
    check("plan_hit_stun", 32'(char2_stun_left), 15);
    check("plan_hit_health", 32'(char2_health), 2);
    check("plan_hit_pulse", 32'(char2_hit_pulse), 1);
    @(posedge clk);
    #1;
    check("plan_pulse_drop", 32'(char2_hit_pulse), 0);

    // held active: no second hit within one window, re-entry lands again
    p2_count = 0;
    repeat (30) tick();
    check("plan_one_hit_window", 32'(p2_count), 0);
    char1_state = 4'd0;
    tick();
    char1_state = 4'd4;
    tick();
    check("plan_rearm_pulse", 32'(char2_hit_pulse), 1);
    check("plan_rearm_health", 32'(char2_health), 1);

    // blocked hit and blockstun expiry
    do_reset();
    set_inputs(100, 4, 0, 292, 0, 1);
    tick();
    check("plan_block_fs", 32'(char2_frame_state), 2);
    check("plan_block_stun", 32'(char2_stun_left), 8);
    check("plan_block_health", 32'(char2_health), 3);
    char1_state = 4'd0;
    repeat (8) tick();
    check("plan_block_end_fs", 32'(char2_frame_state), 0);
    check("plan_block_end_stun", 32'(char2_stun_left), 0);

    // trade: blocking ignored
    do_reset();
    set_inputs(100, 7, 1, 200, 7, 1);
    tick();
    check("plan_trade_fs", 32'({char1_frame_state, char2_frame_state}), 32'h5);
    check("plan_trade_health", 32'({char1_health, char2_health}), 32'ha);
    check("plan_trade_pulses", 32'({char1_hit_pulse, char2_hit_pulse}), 3);

    // three hits end the game, a fourth attack is ignored
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_inputs(100, 4, 0, 292, 0, 0);
      tick();
      char1_state = 4'd0;
      repeat (15) tick();
    end
    check("plan_go_health", 32'(char2_health), 0);
    check("plan_go_flag", 32'(game_over), 1);
    char1_state = 4'd4;
    tick();
    check("plan_go_no_pulse", 32'(char2_hit_pulse), 0);

    // reset in the middle of a stun
    do_reset();
    set_inputs(100, 4, 0, 292, 0, 0);
    tick();
    check("plan_midstun_loaded", 32'(char2_stun_left), 15);
    repeat (3) tick();
    do_reset();

    // geometry cannot wrap; collision is one clock late
    @(negedge clk);
    set_inputs(1000, 0, 0, 10, 0, 0);
    #1;
    check("plan_col_before", 32'(collision_flag), 0);
    @(posedge clk);
    #1;
    check("plan_col_after", 32'(collision_flag), 1);
    tick();

    // randomized ticks against the model
    for (int i = 0; i < 240; i++) begin
      int x1, x2;
      if (i % 40 == 0) do_reset();
      x1 = $urandom_range(0, 1023);
      x2 = x1 + $urandom_range(0, 260);
      if ($urandom_range(0, 7) == 0) x2 = $urandom_range(0, 1023);
      if (x2 > 1023) x2 = 1023;
      set_inputs(x1, state_tbl[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
                 x2, state_tbl[$urandom_range(0, 6)], 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      tick();
    end

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
